// File: rtl/tone_detect.sv
// Tone detector: scans a magnitude frame one bin per cycle, debounces the peak bin
// over HOLD_FRAMES frames and presents detections on a valid/ready output.
// Optional macro TONE_DETECT_DOMINANCE_EN adds a max >= 2*second-max qualification.
module tone_detect #(
    parameter int NUM_FREQS   = 10,
    parameter int MAG_WIDTH   = 18,
    parameter int HOLD_FRAMES = 3,
    localparam int IDX_W      = (NUM_FREQS > 1) ? $clog2(NUM_FREQS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_FREQS*MAG_WIDTH-1:0] mag_in,
    input  logic                           mag_valid,
    input  logic [MAG_WIDTH-2:0]           thresh,
    output logic [IDX_W-1:0]               tone_idx,
    output logic [MAG_WIDTH-2:0]           tone_mag,
    output logic                           tone_valid,
    input  logic                           tone_ready,
    output logic                           busy,
    output logic                           overrun,
    input  logic                           ovr_clr
);

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE, OUT} state_t;

    localparam logic [3:0]       HOLD_C   = 4'(HOLD_FRAMES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FREQS - 1);

    state_t                         state_q, state_d;
    logic [NUM_FREQS*MAG_WIDTH-1:0] frame_q;
    logic [MAG_WIDTH-2:0]           thresh_q;
    logic [IDX_W-1:0]               scan_idx_q;
    logic [MAG_WIDTH-2:0]           max_q;
    logic [IDX_W-1:0]               max_idx_q;
    logic [3:0]                     cnt_q, cnt_next;
    logic [IDX_W-1:0]               cand_q;
    logic [MAG_WIDTH-1:0]           cur_raw;
    logic [MAG_WIDTH-2:0]           cur_mag;
    logic                           last_bin, qualify, same_idx, declare;

    // The frame register shifts down one bin per SCAN cycle, so bin 0 of what is left is current
    assign cur_raw  = frame_q[MAG_WIDTH-1:0];
    assign cur_mag  = cur_raw[MAG_WIDTH-1] ? '0 : cur_raw[MAG_WIDTH-2:0];
    assign last_bin = (scan_idx_q == LAST_IDX);
    assign same_idx = (max_idx_q == cand_q);

`ifdef TONE_DETECT_DOMINANCE_EN
    logic [MAG_WIDTH-2:0] sec_q;
    logic                 dominant;
    assign dominant = ({1'b0, max_q} >= {sec_q, 1'b0});
    assign qualify  = (max_q > thresh_q) && dominant;
`else
    assign qualify  = (max_q > thresh_q);
`endif

    always_comb begin
        cnt_next = '0;
        if (qualify) begin
            if (!same_idx)
                cnt_next = 4'd1;
            else if (cnt_q == HOLD_C)
                cnt_next = cnt_q;
            else
                cnt_next = cnt_q + 4'd1;
        end
    end

    // Declare only on the transition into HOLD; a saturated same-index count stays silent
    assign declare = qualify && (cnt_next == HOLD_C) && !(same_idx && (cnt_q == HOLD_C));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        busy       = (state_q != IDLE);
        tone_valid = (state_q == OUT);
        case (state_q)
            IDLE:    if (mag_valid) state_d = SCAN;
            SCAN:    if (last_bin) state_d = DECIDE;
            DECIDE:  state_d = declare ? OUT : IDLE;
            OUT:     if (tone_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q    <= '0;
            thresh_q   <= '0;
            scan_idx_q <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            cnt_q      <= '0;
            cand_q     <= '0;
            tone_idx   <= '0;
            tone_mag   <= '0;
`ifdef TONE_DETECT_DOMINANCE_EN
            sec_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (mag_valid) begin
                    frame_q    <= mag_in;
                    thresh_q   <= thresh;
                    scan_idx_q <= '0;
                    max_q      <= '0;
                    max_idx_q  <= '0;
`ifdef TONE_DETECT_DOMINANCE_EN
                    sec_q      <= '0;
`endif
                end
                SCAN: begin
                    frame_q    <= frame_q >> MAG_WIDTH;
                    scan_idx_q <= scan_idx_q + 1'b1;
                    if (cur_mag > max_q) begin
                        max_q     <= cur_mag;
                        max_idx_q <= scan_idx_q;
`ifdef TONE_DETECT_DOMINANCE_EN
                        sec_q     <= max_q;
                    end else if (cur_mag > sec_q) begin
                        sec_q     <= cur_mag;
`endif
                    end
                end
                DECIDE: begin
                    cnt_q  <= cnt_next;
                    cand_q <= qualify ? max_idx_q : '0;
                    if (declare) begin
                        tone_idx <= max_idx_q;
                        tone_mag <= max_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (mag_valid && (state_q != IDLE))
            overrun <= 1'b1;
        else if (ovr_clr)
            overrun <= 1'b0;
    end

endmodule
